// File: rtl/int_ctx_stack.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctx_stack
//  Brief    : Nested-interrupt context stack holding return PC and ALU flags,
//             with occupancy count and sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module int_ctx_stack #(
   parameter int PC_W   = 12,
   parameter int FLAG_W = 2,
   parameter int DEPTH  = 4,
   parameter int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              push,
   input  logic              pop,
   input  logic              clr_err,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [FLAG_W-1:0] flags_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [FLAG_W-1:0] flags_o,
   output logic [LVL_W-1:0]  level_o,
   output logic              valid_o,
   output logic              full_o,
   output logic              ovf_o,
   output logic              unf_o
);

   localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              c_ent_w = PC_W + FLAG_W;
   localparam logic [LVL_W-1:0] c_depth = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] c_one   = LVL_W'(1);

   logic [c_ent_w-1:0] r_mem [DEPTH];
   logic [LVL_W-1:0]   r_level;
   logic               r_ovf;
   logic               r_unf;

   logic               w_valid;
   logic               w_full;
   logic [c_idx_w-1:0] w_top_idx;
   logic [c_ent_w-1:0] w_top;
   logic               w_we;
   logic [c_idx_w-1:0] w_widx;

   assign w_valid   = (r_level != '0);
   assign w_full    = (r_level == c_depth);
   assign w_top_idx = c_idx_w'(r_level - c_one);
   assign w_top     = r_mem[w_top_idx];

   // Push+pop on a non-empty stack overwrites the top; otherwise a push
   // lands at index level (which is 0 for the empty push+pop case).
   always_comb begin
      w_we   = 1'b0;
      w_widx = w_top_idx;
      if (!rst && cen && push) begin
         if (pop && w_valid) begin
            w_we = 1'b1;
         end else if (!w_full) begin
            w_we   = 1'b1;
            w_widx = c_idx_w'(r_level);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_widx] <= {pc_i, flags_i};
      end
   end

   // Error sets are written after the clear so a same-cycle error wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (cen) begin
         if (clr_err) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end
         if (push && pop) begin
            if (!w_valid) begin
               r_level <= c_one;
               r_unf   <= 1'b1;
            end
         end else if (push) begin
            if (!w_full) begin
               r_level <= r_level + c_one;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (pop) begin
            if (w_valid) begin
               r_level <= r_level - c_one;
            end else begin
               r_unf <= 1'b1;
            end
         end
      end
   end

   assign pc_o    = w_valid ? w_top[c_ent_w-1:FLAG_W] : '0;
   assign flags_o = w_valid ? w_top[FLAG_W-1:0]       : '0;
   assign level_o = r_level;
   assign valid_o = w_valid;
   assign full_o  = w_full;
   assign ovf_o   = r_ovf;
   assign unf_o   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_int_ctx_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_ctx_stack
//  Brief    : Directed plus randomized bench for int_ctx_stack against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_int_ctx_stack;

   localparam int PC_W   = 12;
   localparam int FLAG_W = 2;
   localparam int DEPTH  = 4;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cen = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic              clr_err = 1'b0;
   logic [PC_W-1:0]   pc_i = '0;
   logic [FLAG_W-1:0] flags_i = '0;
   logic [PC_W-1:0]   pc_o;
   logic [FLAG_W-1:0] flags_o;
   logic [LVL_W-1:0]  level_o;
   logic              valid_o;
   logic              full_o;
   logic              ovf_o;
   logic              unf_o;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   int_ctx_stack #(.PC_W(PC_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cen(cen), .push(push), .pop(pop),
      .clr_err(clr_err), .pc_i(pc_i), .flags_i(flags_i),
      .pc_o(pc_o), .flags_o(flags_o), .level_o(level_o),
      .valid_o(valid_o), .full_o(full_o), .ovf_o(ovf_o), .unf_o(unf_o)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of {pc, flags}, back element is the top.
   logic [PC_W+FLAG_W-1:0] stk[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (cen) begin
         if (clr_err) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (push && pop) begin
            if (stk.size() > 0) begin
               stk[stk.size()-1] = {pc_i, flags_i};
            end else begin
               stk.push_back({pc_i, flags_i});
               m_unf = 1'b1;
            end
         end else if (push) begin
            if (stk.size() < DEPTH) stk.push_back({pc_i, flags_i});
            else m_ovf = 1'b1;
         end else if (pop) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else m_unf = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [PC_W+FLAG_W-1:0] top;
         top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
         check("model_pc",    32'(pc_o),    32'(top[PC_W+FLAG_W-1:FLAG_W]));
         check("model_flags", 32'(flags_o), 32'(top[FLAG_W-1:0]));
         check("model_level", 32'(level_o), stk.size());
         check("model_valid", 32'(valid_o), 32'(stk.size() != 0));
         check("model_full",  32'(full_o),  32'(stk.size() == DEPTH));
         check("model_ovf",   32'(ovf_o),   32'(m_ovf));
         check("model_unf",   32'(unf_o),   32'(m_unf));
      end
   end

   task automatic step(input bit c, input bit ps, input bit pp, input bit ce,
                       input logic [PC_W-1:0] pc, input logic [FLAG_W-1:0] fl);
      cen = c; push = ps; pop = pp; clr_err = ce; pc_i = pc; flags_i = fl;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      step(1, 0, 0, 0, 0, 0);
      check("rst_pc", 32'(pc_o), 0);
      check("rst_level", 32'(level_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_full", 32'(full_o), 0);
      check("rst_err", 32'({ovf_o, unf_o}), 0);
      step(0, 1, 0, 0, 12'h123, 2'b11);
      check("cen0_level", 32'(level_o), 0);

      step(1, 1, 0, 0, 12'h100, 2'b01);
      step(1, 1, 0, 0, 12'h200, 2'b10);
      step(1, 1, 0, 0, 12'h300, 2'b11);
      check("nest_pc3", 32'(pc_o), 32'h300);
      check("nest_fl3", 32'(flags_o), 3);
      check("nest_lvl3", 32'(level_o), 3);
      step(1, 0, 1, 0, 0, 0);
      check("pop_pc2", 32'(pc_o), 32'h200);
      check("pop_fl2", 32'(flags_o), 2);
      check("pop_lvl2", 32'(level_o), 2);
      step(1, 0, 1, 0, 0, 0);
      check("pop_pc1", 32'(pc_o), 32'h100);
      check("pop_lvl1", 32'(level_o), 1);
      step(1, 0, 1, 0, 0, 0);
      check("pop_pc0", 32'(pc_o), 0);
      check("pop_valid0", 32'(valid_o), 0);

      for (int i = 1; i <= 5; i++) begin
         step(1, 1, 0, 0, PC_W'(i), 2'b00);
         if (i == 4) check("ovf_full4", 32'(full_o), 1);
      end
      check("ovf_set", 32'(ovf_o), 1);
      check("ovf_pc", 32'(pc_o), 32'h004);
      check("ovf_lvl", 32'(level_o), 4);
      step(1, 0, 0, 1, 0, 0);
      check("ovf_clr", 32'(ovf_o), 0);
      repeat (4) step(1, 0, 1, 0, 0, 0);

      step(1, 0, 1, 0, 0, 0);
      check("unf_set", 32'(unf_o), 1);
      check("unf_lvl", 32'(level_o), 0);
      step(1, 0, 1, 1, 0, 0);
      check("unf_set_wins", 32'(unf_o), 1);
      step(1, 0, 0, 1, 0, 0);

      step(1, 1, 0, 0, 12'h010, 2'b00);
      step(1, 1, 0, 0, 12'h020, 2'b00);
      step(1, 1, 1, 0, 12'h0AA, 2'b01);
      check("swap_lvl", 32'(level_o), 2);
      check("swap_pc", 32'(pc_o), 32'h0AA);
      step(1, 0, 1, 0, 0, 0);
      check("swap_below", 32'(pc_o), 32'h010);
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 12'h055, 2'b10);
      check("empty_pp_lvl", 32'(level_o), 1);
      check("empty_pp_pc", 32'(pc_o), 32'h055);
      check("empty_pp_unf", 32'(unf_o), 1);

      step(1, 1, 0, 1, 12'h066, 2'b00);
      step(1, 1, 0, 0, 12'h077, 2'b00);
      check("mid_lvl3", 32'(level_o), 3);
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      check("midrst_lvl", 32'(level_o), 0);
      check("midrst_pc", 32'(pc_o), 0);
      step(1, 1, 0, 0, 12'h777, 2'b01);
      check("after_rst_pc", 32'(pc_o), 32'h777);
      check("after_rst_lvl", 32'(level_o), 1);

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              PC_W'($urandom), FLAG_W'($urandom));
      end
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/int_ctx_stack.md
# int_ctx_stack

Parametrised interrupt-context stack for the CPU core, supporting nested interrupts. On interrupt entry the core pushes the return PC and the ALU flags (carry, zero). On return-from-interrupt it pops them. The top entry is always presented to the PC mux and flag restore logic. Depth, PC width and flag count are parameters, and the block reports occupancy plus sticky overflow/underflow errors.

## Interface
- Reset is synchronous and active-high. The block has one clock, `clk`, and one reset, `rst`.
- `PC_W`, default 12: width of the saved program counter.
- `FLAG_W`, default 2: number of saved flags; bit 0 = carry, bit 1 = zero.
- `DEPTH`, default 4: maximum nesting depth, ≥ 2.
- `LVL_W`, derived as $clog2(DEPTH+1): width of `level_o`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `cen`  in  1  clock enable; when 0, `push`/`pop`/`clr_err` are ignored.
- `push`  in  1  save `pc_i`/`flags_i` as new top (interrupt entry).
- `pop`  in  1  discard top entry (RETI).
- `clr_err`  in  1  clear the sticky error bits.
- `pc_i`  in  PC_W  return address to save.
- `flags_i`  in  FLAG_W  flags to save.
- `pc_o`  out  PC_W  top-of-stack PC; 0 when empty.
- `flags_o`  out  FLAG_W  top-of-stack flags; 0 when empty.
- `level_o`  out  LVL_W  number of valid entries.
- `valid_o`  out  1  `level_o != 0`.
- `full_o`  out  1  `level_o == DEPTH`.
- `ovf_o`  out  1  sticky: a push was rejected.
- `unf_o`  out  1  sticky: a pop was issued while empty.

## Operation
- Storage is DEPTH entries of {PC_W+FLAG_W} bits plus an occupancy counter. The top entry is at index level-1.
- All state updates happen on `posedge clk`. `clk` is never gated; `cen` only qualifies updates.
- `rst` has priority over everything, including `cen = 0`. It clears level, `ovf_o` and `unf_o`. Entry contents need not be cleared, but outputs read 0 while empty.
- Operations apply only when `cen = 1`:
  - push only, level < DEPTH: write entry[level]; level+1.
  - push only, full: no write, level unchanged; set `ovf_o`.
  - pop only, level > 0: level-1. The popped entry is not cleared.
  - pop only, empty: no change; set `unf_o`.
  - push and pop, level > 0: replace the top entry in place; level unchanged; no error. This includes the full case.
  - push and pop, empty: the push executes (level becomes 1), the pop is ignored, and `unf_o` is set.
- `clr_err` clears both sticky bits. If an error occurs in the same cycle, the set wins.
- `pc_o`/`flags_o` decode combinationally from registered state (level and entries). There is no combinational path from `push`/`pop`/`pc_i` to any output.
- `level_o` never exceeds DEPTH and never goes below 0. The counter must not wrap.

## Timing
- Output values after reset: `pc_o` = 0, `flags_o` = 0, `level_o` = 0, `valid_o` = 0, `full_o` = 0, `ovf_o` = 0, `unf_o` = 0.
- Push latency is 1 cycle: data sampled at edge N appears on `pc_o`/`flags_o` after edge N.
- Pop latency is 1 cycle: the previous entry, or zeros if now empty, is visible after the edge.
- `full_o`, `valid_o` and the error bits update on the same edge as level.
- A reset in the middle of nested interrupts discards all entries. On the next cycle a push behaves as the first push.
- Back-to-back push/pop every cycle is supported with no bubbles.

## Test plan
- Reset then idle: all outputs are 0. Hold `cen` = 0 while pulsing push: level stays 0.
- Push PC 0x100/flags 01, then 0x200/10, then 0x300/11, then pop ×3:
  - `pc_o` sequence 0x300, 0x200, 0x100, then 0.
  - `level_o` 3→2→1→0.
  - `valid_o` falls after the last pop.
- Overflow with DEPTH = 4: push 5 times (0x001..0x005):
  - `full_o` = 1 after the 4th push.
  - The 5th push sets `ovf_o` = 1; `pc_o` stays 0x004 and level stays 4.
  - `clr_err` clears `ovf_o`.
- Underflow: pop when empty sets `unf_o` = 1 with level 0. Then `clr_err` and pop together: `unf_o` stays 1.
- Simultaneous operations:
  - At level 2 with top 0x020, push 0x0AA together with pop: level stays 2 and `pc_o` = 0x0AA.
  - When empty, push 0x055 together with pop: level becomes 1, `pc_o` = 0x055, `unf_o` = 1.
- Reset mid-operation: at level 3, assert `rst` with `cen` = 0. After the edge, level = 0 and outputs are 0. The next push of 0x777 gives `pc_o` = 0x777 and level 1.
